// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

   // Sequencer control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Branch condition codes
   localparam logic [2:0] COND_NE = 3'd0;
   localparam logic [2:0] COND_EQ = 3'd1;
   localparam logic [2:0] COND_GT = 3'd2;
   localparam logic [2:0] COND_LT = 3'd3;
   localparam logic [2:0] COND_GE = 3'd4;
   localparam logic [2:0] COND_LE = 3'd5;
   localparam logic [2:0] COND_OV = 3'd6;
   localparam logic [2:0] COND_UN = 3'd7;

   // Bit positions inside the {N,V,Z} flag vector
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   // Opcode that stops the sequencer until reset
   localparam logic [3:0] HALT_OPC_DEF = 4'hF;

   // Evaluate a branch condition code against the current flags
   function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
      logic n, v, z;
      n = flags[FLAG_N];
      v = flags[FLAG_V];
      z = flags[FLAG_Z];
      case (cond)
         COND_NE: cond_true = ~z;
         COND_EQ: cond_true = z;
         COND_GT: cond_true = ~z & ~n;
         COND_LT: cond_true = n;
         COND_GE: cond_true = z | ~n;
         COND_LE: cond_true = n | z;
         COND_OV: cond_true = v;
         default: cond_true = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
interface pc_sequencer_if #(
   parameter int PC_W = 16
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_rdy;
   logic [15:0]     imem_data;

   // Sequencer side: issues requests, receives instruction words
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdy,
      input  imem_data
   );

   // Memory side: answers requests
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdy,
      output imem_data
   );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or register branch.
module pc_next_calc
   import pc_seq_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic [PC_W-1:0] i_pc,
   input  logic            i_br_en,
   input  logic            i_breg_en,
   input  logic [2:0]      i_br_cond,
   input  logic [8:0]      i_br_imm,
   input  logic [PC_W-1:0] i_breg_target,
   input  logic [2:0]      i_flags,
   output logic [PC_W-1:0] o_pc_plus2,
   output logic [PC_W-1:0] o_next_pc,
   output logic            o_taken
);

   logic            w_cond;
   logic [PC_W-1:0] w_br_off;

   assign w_cond     = cond_true(i_br_cond, i_flags);
   // Word offset becomes a byte offset; sign extension happens through the signed size cast
   assign w_br_off   = PC_W'($signed({i_br_imm, 1'b0}));
   assign o_pc_plus2 = i_pc + PC_W'(2);
   assign o_taken    = (i_br_en | i_breg_en) & w_cond;

   // Register branch outranks PC-relative branch; both share the same condition
   always_comb begin
      o_next_pc = o_pc_plus2;
      if (i_breg_en && w_cond) begin
         o_next_pc = i_breg_target;
      end else if (i_br_en && w_cond) begin
         o_next_pc = o_pc_plus2 + w_br_off;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner and fetch/execute sequencer for the 16-bit core.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [3:0]      HALT_OPC = HALT_OPC_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   pc_sequencer_if.master  imem,
   output logic            o_instr_vld,
   output logic [15:0]     o_instr_out,
   input  logic            i_stall,
   input  logic            i_br_en,
   input  logic            i_breg_en,
   input  logic [2:0]      i_br_cond,
   input  logic [8:0]      i_br_imm,
   input  logic [PC_W-1:0] i_breg_target,
   input  logic [2:0]      i_flags,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_pc_plus2,
   output logic            o_halted,
   output logic            o_br_taken
);

   state_t          r_state;
   state_t          w_state_next;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_instr;
   logic            r_halted;

   logic            w_req;
   logic            w_vld;
   logic            w_load_instr;
   logic            w_load_pc;
   logic            w_set_halt;
   logic [PC_W-1:0] w_next_pc;

   pc_next_calc #(.PC_W(PC_W)) u_next (
      .i_pc          (r_pc),
      .i_br_en       (i_br_en),
      .i_breg_en     (i_breg_en),
      .i_br_cond     (i_br_cond),
      .i_br_imm      (i_br_imm),
      .i_breg_target (i_breg_target),
      .i_flags       (i_flags),
      .o_pc_plus2    (o_pc_plus2),
      .o_next_pc     (w_next_pc),
      .o_taken       (o_br_taken)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and control strobes; stall freezes EXEC ahead of halt and branch
   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_vld        = 1'b0;
      w_load_instr = 1'b0;
      w_load_pc    = 1'b0;
      w_set_halt   = 1'b0;
      case (r_state)
         IDLE: w_state_next = FETCH;
         FETCH: begin
            w_req = 1'b1;
            if (imem.imem_rdy) begin
               w_load_instr = 1'b1;
               w_state_next = EXEC;
            end
         end
         EXEC: begin
            w_vld = 1'b1;
            if (!i_stall) begin
               if (r_instr[15:12] == HALT_OPC) begin
                  w_set_halt   = 1'b1;
                  w_state_next = HALT;
               end else begin
                  w_load_pc    = 1'b1;
                  w_state_next = FETCH;
               end
            end
         end
         HALT:    w_state_next = HALT;
         default: w_state_next = IDLE;
      endcase
   end

   // Architectural registers: PC, held instruction, sticky halt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_instr  <= '0;
         r_halted <= 1'b0;
      end else begin
         if (w_load_instr) r_instr  <= imem.imem_data;
         if (w_load_pc)    r_pc     <= w_next_pc;
         if (w_set_halt)   r_halted <= 1'b1;
      end
   end

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_pc;
   assign o_instr_vld    = w_vld;
   assign o_instr_out    = r_instr;
   assign o_pc           = r_pc;
   assign o_halted       = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expected next PCs are queued when an
// instruction is presented and popped when the sequencer commits it.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        instr_vld;
   logic [15:0] instr_out;
   logic        stall;
   logic        br_en;
   logic        breg_en;
   logic [2:0]  br_cond;
   logic [8:0]  br_imm;
   logic [15:0] breg_target;
   logic [2:0]  flags;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        halted;
   logic        br_taken;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_txn    = 0;
   logic [15:0] model_pc;
   logic [15:0] sb_q[$];

   pc_sequencer_if #(.PC_W(16)) imem_if ();

   pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .HALT_OPC(4'hF)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (imem_if),
      .o_instr_vld   (instr_vld),
      .o_instr_out   (instr_out),
      .i_stall       (stall),
      .i_br_en       (br_en),
      .i_breg_en     (breg_en),
      .i_br_cond     (br_cond),
      .i_br_imm      (br_imm),
      .i_breg_target (breg_target),
      .i_flags       (flags),
      .o_pc          (pc),
      .o_pc_plus2    (pc_plus2),
      .o_halted      (halted),
      .o_br_taken    (br_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference condition table, written directly from the condition-code list
   function automatic logic model_cond(input logic [2:0] c, input logic [2:0] f);
      logic n, v, z;
      n = f[2];
      v = f[1];
      z = f[0];
      case (c)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || (!z && !n);
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [15:0] model_next(input logic [15:0] p);
      logic [15:0] p2;
      logic        ok;
      p2 = 16'(p + 16'd2);
      ok = model_cond(br_cond, flags);
      if (breg_en && ok)    return breg_target;
      else if (br_en && ok) return 16'(p2 + {{6{br_imm[8]}}, br_imm, 1'b0});
      else                  return p2;
   endfunction

   task automatic set_br(input logic b, input logic br, input logic [2:0] c,
                         input logic [8:0] imm, input logic [15:0] tgt, input logic [2:0] f);
      br_en       = b;
      breg_en     = br;
      br_cond     = c;
      br_imm      = imm;
      breg_target = tgt;
      flags       = f;
   endtask

   // Entered with the sequencer in FETCH; leaves it one cycle after the commit
   task automatic do_instr(input logic [15:0] data, input int delay, input int stalls);
      logic [15:0] pre;
      logic [15:0] got;
      logic        is_halt;
      logic        exp_taken;
      int          req_cycles;
      pre        = model_pc;
      is_halt    = (data[15:12] == 4'hF);
      req_cycles = 0;
      check("fetch_addr", 32'(imem_if.imem_addr), 32'(pre));
      for (int i = 0; i < delay; i++) begin
         if (imem_if.imem_req) req_cycles++;
         tick();
      end
      imem_if.imem_rdy  = 1'b1;
      imem_if.imem_data = data;
      if (imem_if.imem_req) req_cycles++;
      check("req_cycles", 32'(req_cycles), 32'(delay + 1));
      tick();
      imem_if.imem_rdy  = 1'b0;
      imem_if.imem_data = 16'hDEAD;
      check("exec_vld", 32'(instr_vld), 32'd1);
      check("exec_req", 32'(imem_if.imem_req), 32'd0);
      check("instr_out", 32'(instr_out), 32'(data));
      check("pc_plus2", 32'(pc_plus2), 32'(16'(pre + 16'd2)));
      exp_taken = (br_en || breg_en) && model_cond(br_cond, flags);
      check("taken", 32'(br_taken), 32'(exp_taken));
      if (!is_halt) sb_q.push_back(model_next(pre));
      stall = (stalls > 0);
      for (int i = 0; i < stalls; i++) begin
         tick();
         check("stall_vld", 32'(instr_vld), 32'd1);
         check("stall_pc", 32'(pc), 32'(pre));
         check("stall_instr", 32'(instr_out), 32'(data));
      end
      stall = 1'b0;
      tick();
      if (is_halt) begin
         check("halt_flag", 32'(halted), 32'd1);
         check("halt_pc", 32'(pc), 32'(pre));
         check("halt_vld", 32'(instr_vld), 32'd0);
         $display("txn %0d instr=%h pc=%h halted", n_txn, data, pre);
      end else begin
         got = sb_q.pop_front();
         check("next_pc", 32'(pc), 32'(got));
         check("vld_drop", 32'(instr_vld), 32'd0);
         check("refetch_req", 32'(imem_if.imem_req), 32'd1);
         $display("txn %0d instr=%h pc=%h next=%h taken=%0d", n_txn, data, pre, got, exp_taken);
         model_pc = got;
      end
      n_txn++;
   endtask

   initial begin
      rst_n             = 1'b0;
      stall             = 1'b0;
      imem_if.imem_rdy  = 1'b0;
      imem_if.imem_data = 16'h0000;
      set_br(1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 3'b000);
      model_pc = 16'h0000;

      // Reset state
      repeat (3) tick();
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_req", 32'(imem_if.imem_req), 32'd0);
      check("rst_vld", 32'(instr_vld), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_instr", 32'(instr_out), 32'h0);
      rst_n = 1'b1;
      check("idle_req", 32'(imem_if.imem_req), 32'd0);
      check("idle_pc", 32'(pc), 32'h0);
      tick();
      check("fetch_req", 32'(imem_if.imem_req), 32'd1);

      // Sequential fetch with three wait cycles
      do_instr(16'h1234, 3, 0);
      // BR not taken (NE with Z=1), then BR taken to 0x0010
      set_br(1'b0, 1'b1, 3'd0, 9'd0, 16'h0100, 3'b001);
      do_instr(16'h2001, 0, 0);
      set_br(1'b0, 1'b1, 3'd7, 9'd0, 16'h0010, 3'b000);
      do_instr(16'h2002, 1, 0);
      // B unconditional -2 words
      set_br(1'b1, 1'b0, 3'd7, 9'h1FE, 16'h0000, 3'b000);
      do_instr(16'h3001, 0, 0);
      set_br(1'b0, 1'b1, 3'd7, 9'd0, 16'h0010, 3'b000);
      do_instr(16'h2003, 0, 0);
      // B EQ with Z=0: not taken
      set_br(1'b1, 1'b0, 3'd1, 9'h1FE, 16'h0000, 3'b000);
      do_instr(16'h3002, 0, 0);
      set_br(1'b0, 1'b1, 3'd7, 9'd0, 16'h0010, 3'b000);
      do_instr(16'h2004, 0, 0);
      // B GE with all flags clear: taken
      set_br(1'b1, 1'b0, 3'd4, 9'h1FE, 16'h0000, 3'b000);
      do_instr(16'h3003, 2, 0);
      // B LT with N=1, forward +5 words
      set_br(1'b1, 1'b0, 3'd3, 9'h005, 16'h0000, 3'b100);
      do_instr(16'h3004, 0, 0);
      // B OV with V=0: not taken; GT with Z=0,N=1: not taken
      set_br(1'b1, 1'b0, 3'd6, 9'h005, 16'h0000, 3'b101);
      do_instr(16'h3005, 0, 0);
      set_br(1'b1, 1'b0, 3'd2, 9'h005, 16'h0000, 3'b100);
      do_instr(16'h3006, 0, 0);
      // LE with Z=1 taken via BR to 0x0040
      set_br(1'b0, 1'b1, 3'd5, 9'd0, 16'h0040, 3'b001);
      do_instr(16'h2005, 0, 0);
      // BR beats B when both set
      set_br(1'b1, 1'b1, 3'd7, 9'h1FE, 16'hBEEF, 3'b000);
      do_instr(16'h4001, 0, 0);
      // Move to 0xFFFE, then stall three cycles and wrap
      set_br(1'b0, 1'b1, 3'd7, 9'd0, 16'hFFFE, 3'b000);
      do_instr(16'h2006, 0, 0);
      set_br(1'b0, 1'b0, 3'd7, 9'd0, 16'h0000, 3'b000);
      do_instr(16'h5001, 0, 3);
      // Halt, with a branch request that must be ignored
      set_br(1'b1, 1'b1, 3'd7, 9'h010, 16'h1234, 3'b000);
      do_instr(16'hF000, 1, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("halt_hold_req", 32'(imem_if.imem_req), 32'd0);
         check("halt_hold_pc", 32'(pc), 32'(model_pc));
         check("halt_hold_flag", 32'(halted), 32'd1);
      end

      // Reset out of HALT
      set_br(1'b0, 1'b0, 3'd0, 9'd0, 16'h0000, 3'b000);
      #2 rst_n = 1'b0;
      #1;
      check("rst_halt_clr", 32'(halted), 32'd0);
      check("rst_halt_pc", 32'(pc), 32'h0);
      tick();
      rst_n    = 1'b1;
      model_pc = 16'h0000;
      tick();
      do_instr(16'h6001, 0, 0);

      // Reset asserted mid-fetch, between clock edges
      tick();
      check("midfetch_req", 32'(imem_if.imem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_pc", 32'(pc), 32'h0);
      check("abort_req", 32'(imem_if.imem_req), 32'd0);
      check("abort_instr", 32'(instr_out), 32'h0);
      tick();
      rst_n    = 1'b1;
      model_pc = 16'h0000;
      tick();
      do_instr(16'h7001, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
